// File: rtl/adc_uart_tx.sv
// adc_uart_tx: buffers 12-bit ADC samples in a FIFO and sends each one over
// an 8N1 UART as two bytes, high byte ({4'b0, sample[11:8]}) first.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   adc_data           - 12-bit sample, captured only when adc_data_valid_go=1
//   adc_data_valid_go  - one-cycle push strobe
//   uart_tx            - serial line, idle high (registered)
//   tx_busy            - FIFO non-empty or frame in progress (registered)
//   fifo_full          - FIFO holds FIFO_DEPTH samples (registered)
//   drop_go            - one-cycle pulse per sample discarded on full (registered)
module adc_uart_tx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] adc_data,
    input  logic        adc_data_valid_go,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        fifo_full,
    output logic        drop_go
);

    localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int unsigned TW         = $clog2(BIT_CYCLES + 1);
    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam int unsigned CW         = AW + 1;
    localparam int unsigned DW         = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    logic [DW-1:0] fifo_mem [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          byte_sel_q, byte_sel_d;
    logic [7:0]    lo_byte_q, lo_byte_d;
    logic [7:0]    shift_q, shift_d;
    logic          uart_tx_q, uart_tx_d;
    logic          tx_busy_q, tx_busy_d;
    logic          fifo_full_q, fifo_full_d;
    logic          drop_go_q, drop_go_d;

    logic          full_c;
    logic          empty_c;
    logic          push_c;
    logic          pop_c;
    logic          bit_done_c;
    logic [DW-1:0] rdata_c;

    // Full is judged on the pre-edge count, so a same-edge pop cannot rescue a push
    assign full_c     = (count_q == CW'(FIFO_DEPTH));
    assign empty_c    = (count_q == '0);
    assign push_c     = adc_data_valid_go && !full_c;
    assign bit_done_c = (timer_q == TW'(BIT_CYCLES - 1));
    assign rdata_c    = fifo_mem[rd_ptr_q];

    // Sample storage
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= adc_data;
        end
    end

    // FIFO bookkeeping and registered status outputs
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        fifo_full_d = (count_d == CW'(FIFO_DEPTH));
        drop_go_d   = adc_data_valid_go && full_c;
        tx_busy_d   = !empty_c || (state_q != ST_IDLE);
    end

    // UART framing FSM: next state, bit timer, shift register and line level
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        byte_sel_d = byte_sel_q;
        lo_byte_d  = lo_byte_q;
        shift_d    = shift_q;
        pop_c      = 1'b0;
        uart_tx_d  = 1'b1;

        case (state_q)
            ST_IDLE: begin
                uart_tx_d = 1'b1;
                timer_d   = '0;
                if (!empty_c) begin
                    pop_c      = 1'b1;
                    lo_byte_d  = rdata_c[7:0];
                    shift_d    = {4'b0000, rdata_c[11:8]};
                    byte_sel_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                uart_tx_d = 1'b0;
                timer_d   = timer_q + TW'(1);
                if (bit_done_c) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                uart_tx_d = shift_q[0];
                timer_d   = timer_q + TW'(1);
                if (bit_done_c) begin
                    timer_d   = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'(1);
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                uart_tx_d = 1'b1;
                timer_d   = timer_q + TW'(1);
                if (bit_done_c) begin
                    timer_d = '0;
                    if (!byte_sel_q) begin
                        // Low byte follows immediately, no idle gap
                        byte_sel_d = 1'b1;
                        shift_d    = lo_byte_q;
                        state_d    = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            byte_sel_q  <= 1'b0;
            lo_byte_q   <= '0;
            shift_q     <= '0;
            uart_tx_q   <= 1'b1;
            tx_busy_q   <= 1'b0;
            fifo_full_q <= 1'b0;
            drop_go_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            byte_sel_q  <= byte_sel_d;
            lo_byte_q   <= lo_byte_d;
            shift_q     <= shift_d;
            uart_tx_q   <= uart_tx_d;
            tx_busy_q   <= tx_busy_d;
            fifo_full_q <= fifo_full_d;
            drop_go_q   <= drop_go_d;
        end
    end

    assign uart_tx   = uart_tx_q;
    assign tx_busy   = tx_busy_q;
    assign fifo_full = fifo_full_q;
    assign drop_go   = drop_go_q;

endmodule

// File: tb/tb_adc_uart_tx.sv
// Testbench for adc_uart_tx. Runs with a short bit period (1.05 MHz / 100 kbaud
// -> 10 clocks per bit after truncation) so long bursts finish quickly.
// Stimulus pushes expected bytes into a queue; a UART decoder pops and compares.
module tb_adc_uart_tx;

    localparam int B = 10;    // clocks per bit, hand-computed for the overrides below

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] adc_data = '0;
    logic        adc_data_valid_go = 1'b0;
    logic        uart_tx;
    logic        tx_busy;
    logic        fifo_full;
    logic        drop_go;

    adc_uart_tx #(
        .CLK_FREQ   (1_050_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (128)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .adc_data          (adc_data),
        .adc_data_valid_go (adc_data_valid_go),
        .uart_tx           (uart_tx),
        .tx_busy           (tx_busy),
        .fifo_full         (fifo_full),
        .drop_go           (drop_go)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected entries: {b2b_sample, is_low_byte, byte}
    logic [9:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [11:0] s, input logic b2b);
        exp_q.push_back({b2b, 1'b0, 4'b0000, s[11:8]});
        exp_q.push_back({1'b0, 1'b1, s[7:0]});
    endtask

    // Drive a strobe for the next posedge; caller ends it with release_in
    task automatic strobe(input logic [11:0] d, input logic accept, input logic b2b);
        @(negedge clk);
        adc_data          = d;
        adc_data_valid_go = 1'b1;
        if (accept) push_exp(d, b2b);
    endtask

    task automatic release_in();
        @(negedge clk);
        adc_data_valid_go = 1'b0;
        adc_data          = 12'($urandom);
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (tx_busy && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle_tx_busy", int'(tx_busy), 0);
    endtask

    // Status observers
    int drop_cnt = 0;
    int full_seen = 0;
    always @(negedge clk) begin
        if (drop_go)   drop_cnt++;
        if (fifo_full) full_seen++;
    end

    // UART decoder / scoreboard monitor
    int         mcyc = 0;
    int         dstate = 0;
    int         cnt = 0;
    int         kbit = 0;
    int         start_cyc = 0;
    int         prev_start = 0;
    int         nbytes = 0;
    logic [7:0] sh = '0;
    logic       frame_ok = 1'b1;

    task automatic byte_done();
        logic [9:0] e;
        nbytes++;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_byte: actual 0x%0h expected none at %0t", sh, $time);
        end else begin
            e = exp_q.pop_front();
            check("byte_value", int'(sh), int'(e[7:0]));
            check("framing", int'(frame_ok), 1);
            if (e[8])
                check("byte_gap", start_cyc - prev_start, 10 * B);
            else if (e[9])
                check("sample_gap", start_cyc - prev_start, 10 * B + 1);
        end
        prev_start = start_cyc;
    endtask

    always @(negedge clk) begin
        mcyc++;
        if (!rst_n) begin
            dstate = 0;
        end else if (dstate == 0) begin
            if (uart_tx == 1'b0) begin
                dstate    = 1;
                cnt       = 0;
                start_cyc = mcyc;
                frame_ok  = 1'b1;
            end
        end else begin
            cnt++;
            if (cnt % B == B / 2) begin
                kbit = cnt / B;
                if (kbit == 0) begin
                    frame_ok = frame_ok && (uart_tx == 1'b0);
                end else if (kbit <= 8) begin
                    sh[kbit-1] = uart_tx;
                end else begin
                    frame_ok = frame_ok && (uart_tx == 1'b1);
                    byte_done();
                    dstate = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_uart_tx", int'(uart_tx), 1);
        check("rst_tx_busy", int'(tx_busy), 0);
        check("rst_fifo_full", int'(fifo_full), 0);
        check("rst_drop_go", int'(drop_go), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: single sample, latency and busy duration
        strobe(12'hA5C, 1'b1, 1'b0);
        release_in();                       // after edge N
        check("t1_tx_at_N", int'(uart_tx), 1);
        @(negedge clk);                     // after N+1 (pop)
        check("t1_tx_at_N1", int'(uart_tx), 1);
        check("t1_busy_at_N1", int'(tx_busy), 1);
        @(negedge clk);                     // after N+2
        check("t1_tx_fall_N2", int'(uart_tx), 0);
        repeat (199) @(negedge clk);        // after N+201
        check("t1_busy_before_end", int'(tx_busy), 1);
        @(negedge clk);                     // after N+202 = pop + 201
        check("t1_busy_fall", int'(tx_busy), 0);
        repeat (5) @(negedge clk);

        // 2: 100 strobes spaced 16 cycles, no overflow
        full_seen = 0;
        for (int i = 0; i < 100; i++) begin
            strobe(12'(i), 1'b1, (i != 0));
            release_in();
            repeat (14) @(negedge clk);
        end
        wait_idle(25000);
        check("t2_drops", drop_cnt, 0);
        check("t2_full_seen", full_seen, 0);
        repeat (5) @(negedge clk);

        // 3: 131 back-to-back strobes, FIFO fills, two drops
        for (int i = 0; i < 131; i++) begin
            strobe(12'(i), (i <= 128), (i != 0) && (i <= 128));
            if (i == 128) check("t3_full_at_127", int'(fifo_full), 0);
            if (i == 129) check("t3_full_at_128", int'(fifo_full), 1);
        end
        release_in();                       // after E0+130
        repeat (70) @(negedge clk);         // after E0+200
        check("t3_drops", drop_cnt, 2);
        check("t4_full_before_pop", int'(fifo_full), 1);

        // 4: strobe while full on the same edge as the IDLE pop (E0+202)
        strobe(12'h7EE, 1'b0, 1'b0);
        release_in();                       // after E0+202
        check("t4_drop_go", int'(drop_go), 1);
        check("t4_full_after_pop", int'(fifo_full), 0);
        @(negedge clk);
        check("t4_drop_one_cycle", int'(drop_go), 0);
        wait_idle(40000);
        check("t4_total_drops", drop_cnt, 3);
        repeat (5) @(negedge clk);

        // 5: reset during DATA bit 3 of a high byte with 5 samples buffered
        for (int i = 0; i < 6; i++) strobe(12'h100 + 12'(i), 1'b1, (i != 0));
        release_in();                       // after E0+5
        repeat (40) @(negedge clk);         // after E0+45, wire in bit 3 (a zero)
        check("t5_tx_low_before_rst", int'(uart_tx), 0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_tx_rst", int'(uart_tx), 1);
        check("t5_busy_rst", int'(tx_busy), 0);
        check("t5_full_rst", int'(fifo_full), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("t5_quiet_after_rst", bad, 0);

        // 6: extremes
        strobe(12'hFFF, 1'b1, 1'b0);
        strobe(12'h000, 1'b1, 1'b1);
        release_in();
        repeat (5) @(negedge clk);
        wait_idle(2000);
        repeat (10) @(negedge clk);

        check("exp_queue_empty", exp_q.size(), 0);
        check("bytes_decoded", nbytes, 2 + 200 + 258 + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
